// File: rtl/led_activity_bank.sv
// N-channel front-panel activity indicator: each channel stretches activity
// strobes into fixed-length, visibly separated LED blinks, or follows its input level.
module led_activity_bank #(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 24,
  parameter int HOLD_CYC = 4800000,
  parameter int GAP_CYC  = 2400000,
  parameter int SYNC_IN  = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] in,
  input  logic [N_CH-1:0] mode,
  input  logic [N_CH-1:0] enable,
  output logic [N_CH-1:0] led
);

  typedef enum logic [1:0] {IDLE, ON, GAP} state_e;

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N_CH-1:0] s;
  logic [N_CH-1:0] prev_q;
  logic [N_CH-1:0] rise;

  generate
    if (SYNC_IN != 0) begin : g_sync
      logic [N_CH-1:0] meta_q, sync_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          meta_q <= '0;
          sync_q <= '0;
        end else begin
          meta_q <= in;
          sync_q <= meta_q;
        end
      end
      assign s = sync_q;
    end else begin : g_nosync
      assign s = in;
    end
  endgenerate

  // History keeps tracking while disabled or level-following, so neither
  // re-enable nor a switch back to edge mode fabricates a rise from a held level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_q <= '0;
    else          prev_q <= s;
  end

  assign rise = s & ~prev_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             led_q, led_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      led_d   = 1'b0;
      if (!enable[g]) begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end else if (mode[g]) begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
        led_d   = s[g];
      end else begin
        unique case (state_q)
          IDLE: begin
            if (rise[g]) begin
              state_d = ON;
              cnt_d   = HOLD_LD;
            end
          end
          ON: begin
            pend_d = pend_q | rise[g];
            if (cnt_q == '0) begin
              state_d = GAP;
              cnt_d   = GAP_LD;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          GAP: begin
            pend_d = pend_q | rise[g];
            if (cnt_q == '0) begin
              // A single pending bit collapses any burst into one further blink.
              if (pend_q | rise[g]) begin
                state_d = ON;
                cnt_d   = HOLD_LD;
                pend_d  = 1'b0;
              end else begin
                state_d = IDLE;
              end
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
            pend_d  = 1'b0;
          end
        endcase
        led_d = (state_d == ON);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        pend_q  <= 1'b0;
        led_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pend_q  <= pend_d;
        led_q   <= led_d;
      end
    end

    assign led[g] = led_q;
  end

endmodule

// File: tb/tb_led_activity_bank.sv
// Scoreboard bench for led_activity_bank: one direct-input instance and one
// synchronised-input instance share stimulus; expected LED bits are queued per cycle.
module tb_led_activity_bank;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] in_v = '0;
  logic [3:0] mode_v = '0;
  logic [3:0] en_v = '1;
  logic [3:0] led0, led1;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  typedef struct {
    int    cyc;
    bit    dut;
    int    ch;
    logic  exp;
    string nm;
  } exp_t;

  exp_t sb[$];

  led_activity_bank #(.N_CH(4), .CNT_W(4), .HOLD_CYC(4), .GAP_CYC(3), .SYNC_IN(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .in(in_v), .mode(mode_v), .enable(en_v), .led(led0)
  );

  led_activity_bank #(.N_CH(4), .CNT_W(4), .HOLD_CYC(4), .GAP_CYC(3), .SYNC_IN(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in(in_v), .mode(mode_v), .enable(en_v), .led(led1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every falling edge, retire all expectations due this cycle.
  always @(negedge clk) begin
    int   i;
    logic act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        act = sb[i].dut ? led1[sb[i].ch] : led0[sb[i].ch];
        n_cmp++;
        if (act !== sb[i].exp) begin
          n_bad++;
          $display("FAIL %s dut%0d cyc=%0d ch=%0d led=%b expected=%b",
                   sb[i].nm, sb[i].dut, cyc, sb[i].ch, act, sb[i].exp);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s dut%0d cyc=%0d ch=%0d led=unchecked expected=%b",
                 sb[i].nm, sb[i].dut, sb[i].cyc, sb[i].ch, sb[i].exp);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic exp_rng(input bit d, input int ch, input int c0, input int c1,
                         input logic v, input string nm);
    exp_t e;
    for (int c = c0; c <= c1; c++) begin
      e.cyc = c; e.dut = d; e.ch = ch; e.exp = v; e.nm = nm;
      sb.push_back(e);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int ch = 0; ch < 4; ch++) begin
      exp_rng(0, ch, 1, 3, 1'b0, "reset_state");
      exp_rng(1, ch, 1, 3, 1'b0, "reset_state");
    end
    goto(3);
    reset_n = 1'b1;

    // Single pulses on ch0, held level on ch1
    goto(4);
    exp_rng(0, 0, 4, 10, 1'b0, "ch0_pre");
    exp_rng(0, 0, 11, 14, 1'b1, "ch0_blink");
    exp_rng(0, 0, 15, 18, 1'b0, "ch0_gap");
    exp_rng(0, 0, 19, 22, 1'b1, "ch0_idle_reblink");
    exp_rng(0, 0, 23, 30, 1'b0, "ch0_after");
    exp_rng(1, 0, 4, 12, 1'b0, "sync_ch0_pre");
    exp_rng(1, 0, 13, 16, 1'b1, "sync_ch0_blink");
    exp_rng(1, 0, 17, 20, 1'b0, "sync_ch0_gap");
    exp_rng(1, 0, 21, 24, 1'b1, "sync_ch0_reblink");
    exp_rng(1, 0, 25, 30, 1'b0, "sync_ch0_after");
    exp_rng(0, 1, 4, 10, 1'b0, "ch1_pre");
    exp_rng(0, 1, 11, 14, 1'b1, "ch1_held_blink");
    exp_rng(0, 1, 15, 45, 1'b0, "ch1_held_noreblink");
    exp_rng(1, 1, 4, 12, 1'b0, "sync_ch1_pre");
    exp_rng(1, 1, 13, 16, 1'b1, "sync_ch1_blink");
    exp_rng(1, 1, 17, 45, 1'b0, "sync_ch1_noreblink");
    exp_rng(0, 2, 4, 45, 1'b0, "ch2_quiet");
    exp_rng(0, 3, 4, 45, 1'b0, "ch3_quiet");
    goto(10); in_v[0] = 1'b1; in_v[1] = 1'b1;
    goto(11); in_v[0] = 1'b0;
    goto(18); in_v[0] = 1'b1;
    goto(19); in_v[0] = 1'b0;
    goto(40); in_v[1] = 1'b0;

    // ch2 continuous activity: rises every other cycle, 50..78
    goto(50);
    for (int c = 50; c <= 90; c++)
      exp_rng(0, 2, c, c, (c >= 51 && c <= 85 && ((c - 51) % 7) < 4), "ch2_periodic");
    for (int c = 50; c < 80; c++) begin
      goto(c);
      in_v[2] = ((c % 2) == 0);
    end
    goto(80); in_v[2] = 1'b0;

    // ch3 level-follow, then back to edge mode with input high
    goto(95);
    mode_v[3] = 1'b1;
    exp_rng(0, 3, 96, 100, 1'b0, "ch3_level_pre");
    exp_rng(0, 3, 101, 102, 1'b1, "ch3_level_hi");
    exp_rng(0, 3, 103, 103, 1'b0, "ch3_level_lo");
    exp_rng(0, 3, 104, 105, 1'b1, "ch3_level_hi2");
    exp_rng(0, 3, 106, 115, 1'b0, "ch3_mode0_noblink");
    goto(100); in_v[3] = 1'b1;
    goto(102); in_v[3] = 1'b0;
    goto(103); in_v[3] = 1'b1;
    goto(105); mode_v[3] = 1'b0;
    goto(116); in_v[3] = 1'b0;

    // ch0 enable dropped mid-ON with a pending rise, then re-enabled
    goto(120);
    exp_rng(0, 0, 121, 123, 1'b1, "en_blink_start");
    exp_rng(0, 0, 124, 130, 1'b0, "en_forced_off");
    exp_rng(0, 0, 131, 134, 1'b1, "en_reblink");
    exp_rng(0, 0, 135, 142, 1'b0, "en_pending_cleared");
    in_v[0] = 1'b1;
    goto(121); in_v[0] = 1'b0;
    goto(122); in_v[0] = 1'b1;
    goto(123); in_v[0] = 1'b0; en_v[0] = 1'b0;
    goto(126); en_v[0] = 1'b1;
    goto(130); in_v[0] = 1'b1;
    goto(131); in_v[0] = 1'b0;

    // All channels blink, reset lands mid-GAP, inputs still high on release
    goto(150);
    for (int ch = 0; ch < 4; ch++) begin
      exp_rng(0, ch, 151, 154, 1'b1, "all_blink");
      exp_rng(0, ch, 155, 158, 1'b0, "all_gap_reset");
      exp_rng(0, ch, 159, 162, 1'b1, "post_reset_blink");
      exp_rng(0, ch, 163, 170, 1'b0, "post_reset_single");
      exp_rng(1, ch, 156, 160, 1'b0, "sync_reset");
      exp_rng(1, ch, 161, 164, 1'b1, "sync_post_reset_blink");
      exp_rng(1, ch, 165, 172, 1'b0, "sync_post_reset_single");
    end
    in_v = 4'hF;
    goto(156); reset_n = 1'b0;
    goto(158); reset_n = 1'b1;

    goto(176);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
